// File: rtl/ifetch_ctrl_if.sv
// Instruction fetch controller bundle: instruction bus, decode handshake,
// next-PC predictor and execute redirect, seen from the controller (master).
interface ifetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [63:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [63:0] pred_pc;
    logic        out_valid;
    logic        out_ready;
    logic        out_misalign;
    logic        redirect;
    logic [63:0] redirect_pc;

    modport master (
        output ireq_valid, ireq_addr, fetch_pc, fetch_instr, out_valid, out_misalign,
        input  iresp_data_ok, iresp_data, pred_pc, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, fetch_pc, fetch_instr, out_valid, out_misalign,
        output iresp_data_ok, iresp_data, pred_pc, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Two-state instruction fetch controller: issues one bus request, holds the
// returned word for decode, and folds in execute redirects without disturbing a live request.
module ifetch_ctrl (
    input  logic          clk,
    input  logic          reset,
    ifetch_ctrl_if.master bus
);
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr_q;
    logic        r_mis_q;
    logic        r_pend;
    logic [63:0] r_pend_pc;

    logic w_aligned;
    logic w_fetch;
    logic w_hold;

    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign w_fetch   = (r_state == ST_FETCH);
    assign w_hold    = (r_state == ST_HOLD);

    // Reset gates the strobes combinationally so they drop the instant reset rises.
    assign bus.ireq_valid   = !reset && w_fetch && w_aligned;
    assign bus.ireq_addr    = r_pc;
    assign bus.out_valid    = !reset && w_hold;
    assign bus.out_misalign = !reset && w_hold && r_mis_q;
    assign bus.fetch_pc     = r_pc;
    assign bus.fetch_instr  = r_instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_instr_q <= 32'h0000_0000;
            r_mis_q   <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= 64'h0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!w_aligned) begin
                        r_instr_q <= 32'h0000_0000;
                        r_mis_q   <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else if (bus.iresp_data_ok) begin
                        // A redirect seen during the transaction makes its data stale.
                        if (r_pend || bus.redirect) begin
                            r_pc   <= bus.redirect ? bus.redirect_pc : r_pend_pc;
                            r_pend <= 1'b0;
                        end else begin
                            r_instr_q <= bus.iresp_data;
                            r_mis_q   <= 1'b0;
                            r_state   <= ST_HOLD;
                        end
                    end else if (bus.redirect) begin
                        r_pend    <= 1'b1;
                        r_pend_pc <= bus.redirect_pc;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect) begin
                        r_pc    <= bus.redirect_pc;
                        r_state <= ST_FETCH;
                    end else if (bus.out_ready) begin
                        r_pc    <= bus.pred_pc;
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model of the fetch rules.
module tb_ifetch_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    ifetch_ctrl_if bus ();

    ifetch_ctrl dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predictor: jal-looking words skip 8 bytes, everything else falls through by 4.
    function automatic logic [63:0] pred_fn(input logic [63:0] pc, input logic [31:0] ins);
        return (ins[6:0] == 7'h6f) ? pc + 64'd8 : pc + 64'd4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:7] ^ 25'h0155_AA5, (a[3] ? 7'h6f : 7'h13)};
    endfunction

    assign bus.pred_pc = pred_fn(bus.fetch_pc, bus.fetch_instr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = 32'h0;
        bus.out_ready     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 64'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL reset_ireq_valid got=%0h exp=0", bus.ireq_valid); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", bus.out_valid); end
        total++; if (bus.out_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%0h exp=0", bus.out_misalign); end
        total++; if (bus.fetch_pc !== 64'h8000_0000) begin bad++; $display("FAIL reset_pc got=%0h exp=80000000", bus.fetch_pc); end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        #1;
        total++; if (bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%0h exp=1", bus.ireq_valid); end
        total++; if (bus.ireq_addr !== 64'h8000_0000) begin bad++; $display("FAIL first_req_addr got=%0h exp=80000000", bus.ireq_addr); end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0000_0013;
        tick();
        idle_inputs();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid got=%0h exp=1", bus.out_valid); end
        total++; if (bus.fetch_pc !== 64'h8000_0000) begin bad++; $display("FAIL first_fetch_pc got=%0h exp=80000000", bus.fetch_pc); end
        total++; if (bus.fetch_instr !== 32'h0000_0013) begin bad++; $display("FAIL first_instr got=%0h exp=13", bus.fetch_instr); end
        total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL hold_no_req got=%0h exp=0", bus.ireq_valid); end
        total++; if (bus.out_misalign !== 1'b0) begin bad++; $display("FAIL first_misalign got=%0h exp=0", bus.out_misalign); end
    endtask

    task automatic test_predict();
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.ireq_valid !== 1'b1) begin bad++; $display("FAIL pred_req_valid got=%0h exp=1", bus.ireq_valid); end
        total++; if (bus.ireq_addr !== 64'h8000_0004) begin bad++; $display("FAIL pred_req_addr got=%0h exp=80000004", bus.ireq_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pred_out_valid got=%0h exp=0", bus.out_valid); end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0010_0093;
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect_inflight();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h8000_0000;
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0000)
                begin bad++; $display("FAIL inflight_addr_c%0d got=%0h/%0h exp=1/80000000", c, bus.ireq_valid, bus.ireq_addr); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL inflight_out_valid_c%0d got=%0h exp=0", c, bus.out_valid); end
            if (c == 0) begin
                bus.redirect    = 1'b1;
                bus.redirect_pc = 64'h8000_0100;
            end
            tick();
            idle_inputs();
        end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dropped_out_valid got=%0h exp=0", bus.out_valid); end
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0100)
            begin bad++; $display("FAIL redirected_req got=%0h/%0h exp=1/80000100", bus.ireq_valid, bus.ireq_addr); end
    endtask

    task automatic test_hold_stall();
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h1234_5613;
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.fetch_pc !== 64'h8000_0100 || bus.fetch_instr !== 32'h1234_5613)
                begin bad++; $display("FAIL stall_c%0d got=%0h/%0h/%0h exp=1/80000100/12345613", c, bus.out_valid, bus.fetch_pc, bus.fetch_instr); end
            tick();
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h8000_0200;
        bus.out_ready   = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h8000_0200)
            begin bad++; $display("FAIL redirect_over_ready got=%0h/%0h exp=1/80000200", bus.ireq_valid, bus.ireq_addr); end
    endtask

    task automatic test_misalign();
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0000_0013;
        tick();
        idle_inputs();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'h8000_0002;
        tick();
        idle_inputs();
        total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL misalign_no_req got=%0h exp=0", bus.ireq_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_misalign !== 1'b1)
            begin bad++; $display("FAIL misalign_flag got=%0h/%0h exp=1/1", bus.out_valid, bus.out_misalign); end
        total++; if (bus.fetch_pc !== 64'h8000_0002 || bus.fetch_instr !== 32'h0)
            begin bad++; $display("FAIL misalign_entry got=%0h/%0h exp=80000002/0", bus.fetch_pc, bus.fetch_instr); end
        total++; if (bus.ireq_valid !== 1'b0) begin bad++; $display("FAIL misalign_hold_req got=%0h exp=0", bus.ireq_valid); end
    endtask

    task automatic test_reset_mid_hold();
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%0h exp=0", bus.out_valid); end
        total++; if (bus.out_misalign !== 1'b0) begin bad++; $display("FAIL async_reset_mis got=%0h exp=0", bus.out_misalign); end
        total++; if (bus.fetch_pc !== 64'h8000_0000) begin bad++; $display("FAIL async_reset_pc got=%0h exp=80000000", bus.fetch_pc); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0;
        tick();
        idle_inputs();
        total++; if (bus.ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%0h exp=fffffffffffffffc", bus.ireq_addr); end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data    = 32'h0000_0013;
        tick();
        idle_inputs();
        bus.out_ready = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 64'h0)
            begin bad++; $display("FAIL wrap_next got=%0h/%0h exp=1/0", bus.ireq_valid, bus.ireq_addr); end
    endtask

    task automatic test_random();
        // Model: either presenting an entry, or working on the bus address.
        bit          presenting;
        logic [63:0] addr;
        logic [31:0] word;
        bit          mis;
        bit          stale;
        logic [63:0] target;
        bit          mem_busy;
        int          mem_lat;
        bit          dok, rdr, rdy;
        logic [63:0] rpc;
        logic [31:0] dat;

        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        presenting = 0; addr = 64'h8000_0000; word = 0; mis = 0; stale = 0; target = 0;
        mem_busy = 0; mem_lat = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            total++; if (bus.ireq_valid !== (!presenting && addr[1:0] == 2'b00))
                begin bad++; $display("FAIL rnd_req_valid cyc=%0d got=%0h exp=%0h", cyc, bus.ireq_valid, !presenting && addr[1:0] == 2'b00); end
            if (!presenting && addr[1:0] == 2'b00) begin
                total++; if (bus.ireq_addr !== addr) begin bad++; $display("FAIL rnd_req_addr cyc=%0d got=%0h exp=%0h", cyc, bus.ireq_addr, addr); end
            end
            total++; if (bus.out_valid !== presenting) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", cyc, bus.out_valid, presenting); end
            if (presenting) begin
                total++; if (bus.fetch_pc !== addr || bus.fetch_instr !== word || bus.out_misalign !== mis)
                    begin bad++; $display("FAIL rnd_entry cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, bus.fetch_pc, bus.fetch_instr, bus.out_misalign, addr, word, mis); end
            end

            if (!mem_busy && bus.ireq_valid) begin
                mem_busy = 1;
                mem_lat  = $urandom_range(0, 3);
            end
            dok = mem_busy && (mem_lat == 0);
            dat = dok ? mem_word(bus.ireq_addr) : $urandom();
            rdr = ($urandom_range(0, 99) < 12);
            rdy = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 7))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
                1:       rpc = 64'h8000_0002 + 64'($urandom_range(0, 63) * 4);
                default: rpc = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
            endcase
            bus.iresp_data_ok = dok;
            bus.iresp_data    = dat;
            bus.redirect      = rdr;
            bus.redirect_pc   = rpc;
            bus.out_ready     = rdy;

            if (presenting) begin
                if (rdr) begin addr = rpc; presenting = 0; end
                else if (rdy) begin addr = pred_fn(addr, word); presenting = 0; end
            end else if (addr[1:0] != 2'b00) begin
                presenting = 1; word = 32'h0; mis = 1;
            end else if (dok) begin
                if (stale || rdr) begin addr = rdr ? rpc : target; stale = 0; end
                else begin presenting = 1; word = dat; mis = 0; end
            end else if (rdr) begin
                stale = 1; target = rpc;
            end

            if (mem_busy) begin
                if (dok) mem_busy = 0;
                else mem_lat--;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_first_fetch();
        test_predict();
        test_redirect_inflight();
        test_hold_stall();
        test_misalign();
        test_reset_mid_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL: ireq_valid  out  1  instruction-bus request valid.
REQ-004 SHALL: ireq_addr  out  64  instruction-bus request address.
REQ-005 SHALL: iresp_data_ok  in  1  response data valid this cycle; ends the current transaction.
REQ-006 SHALL: iresp_data  in  32  response instruction word, valid when iresp_data_ok=1.
REQ-007 SHALL: fetch_pc  out  64  PC of the held instruction; also feeds the next-PC predictor.
REQ-008 SHALL: fetch_instr  out  32  held raw instruction; also feeds the next-PC predictor.
REQ-009 SHALL: pred_pc  in  64  combinational next-PC prediction for (fetch_pc, fetch_instr).
REQ-010 SHALL: out_valid  out  1  fetch_pc/fetch_instr/out_misalign valid for decode.
REQ-011 SHALL: out_ready  in  1  decode accepts the held instruction this cycle.
REQ-012 SHALL: out_misalign  out  1  held entry is an instruction-address-misaligned fault.
REQ-013 SHALL: redirect  in  1  execute-stage redirect (mispredict, jalr) this cycle.
REQ-014 SHALL: redirect_pc  in  64  redirect target, valid when redirect=1.

Function
REQ-015 SHALL: state machine with two states, FETCH and HOLD; registers pc(64), instr_q(32), mis_q(1), pend(1), pend_pc(64).
REQ-016 SHALL: FETCH with pc[1:0]=00 -> ireq_valid=1, ireq_addr=pc; out_valid=0.
REQ-017 SHALL: FETCH with pc[1:0]!=00 -> ireq_valid=0; next cycle HOLD with instr_q=0x00000000, mis_q=1 (no bus access).
REQ-018 SHALL: ireq_valid and ireq_addr held constant from assertion until the cycle iresp_data_ok=1, inclusive; redirects never alter them mid-transaction.
REQ-019 SHALL: FETCH, iresp_data_ok=1, pend=0, redirect=0 -> instr_q<=iresp_data, mis_q<=0, next state HOLD.
REQ-020 SHALL: FETCH, iresp_data_ok=0, redirect=1 -> pend<=1, pend_pc<=redirect_pc; later redirects overwrite pend_pc (latest wins).
REQ-021 SHALL: FETCH, iresp_data_ok=1 with pend=1 or redirect=1 -> response discarded; pc<=redirect_pc if redirect=1, else pend_pc; pend<=0; stay FETCH.
REQ-022 SHALL: HOLD -> out_valid=1, fetch_pc=pc, fetch_instr=instr_q, out_misalign=mis_q, ireq_valid=0.
REQ-023 SHALL: HOLD, redirect=1 -> pc<=redirect_pc, next FETCH, regardless of out_ready (redirect has priority; held entry dropped).
REQ-024 SHALL: HOLD, redirect=0, out_ready=1 -> pc<=pred_pc, next FETCH.
REQ-025 SHALL: HOLD, redirect=0, out_ready=0 -> all state held; outputs stable.
REQ-026 SHALL: latency -- data_ok in the request cycle gives out_valid=1 the next cycle; peak throughput one instruction per 2 cycles.
REQ-027 SHALL: pc arithmetic 64-bit, wraps modulo 2^64; no range checking.
REQ-028 SHALL: fetch_pc/fetch_instr also driven from pc/instr_q in FETCH (don't-care to decode, out_valid=0).

Reset
REQ-029 SHALL: on reset: pc=0x0000_0000_8000_0000, state FETCH, instr_q=0, mis_q=0, pend=0, pend_pc=0.
REQ-030 SHALL: while reset=1: ireq_valid=0, out_valid=0, out_misalign=0; first request issued the first cycle after reset deasserts.
REQ-031 SHALL: reset mid-transaction abandons it; a data_ok arriving after reset deassertion for the abandoned request is the memory side's responsibility (bus is reset together).

Verification
REQ-032 SHALL: reset release, data_ok same cycle with 0x00000013 -> next cycle out_valid=1, fetch_pc=0x80000000, fetch_instr=0x00000013.
REQ-033 SHALL: HOLD, out_ready=1, pred_pc=0x80000004 -> next cycle ireq_valid=1, ireq_addr=0x80000004.
REQ-034 SHALL: request at 0x80000000 with data_ok delayed 3 cycles, redirect to 0x80000100 in cycle 1 -> ireq_addr stays 0x80000000 until data_ok, data dropped, next request 0x80000100, out_valid never 1 for 0x80000000.
REQ-035 SHALL: HOLD with out_ready=0 for 5 cycles -> outputs unchanged; then redirect=1 and out_ready=1 same cycle to 0x80000200 -> next request 0x80000200, pred_pc ignored.
REQ-036 SHALL: redirect to 0x80000002 -> no bus request; next cycle out_valid=1, out_misalign=1, fetch_pc=0x80000002, fetch_instr=0.
REQ-037 SHALL: reset asserted mid-HOLD -> out_valid=0 immediately (same cycle, before clk edge), pc=0x80000000.
